// File: rtl/io_scff_chain_ctrl.sv
// io_scff_chain_ctrl: sequencer for the IO scan flip-flop chain behind the
// po_pad output mux. Drives SE0/SE2/SC0/SC1/SR, shifts a word MSB-first into
// the chain head and collects the word leaving the chain tail.
// Optional build macro: IO_SCFF_READBACK_CHECK_EN (readback compare against
// the previously shifted-in word).
module io_scff_chain_ctrl #(
  parameter int CHAIN_LEN = 8,
  parameter int PULSE_W   = 2,
  parameter int GAP_W     = 1
) (
  input  logic                 prog_clk,
  input  logic                 prog_reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [CHAIN_LEN-1:0] cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CHAIN_LEN-1:0] rsp_data,
  output logic                 rsp_mismatch,
  output logic                 busy,
  output logic                 SE0,
  output logic                 SE2,
  output logic                 SC0,
  output logic                 SC1,
  output logic                 SR,
  output logic                 sc_in,
  input  logic                 sc_out
);

  localparam int P   = 2 * (PULSE_W + GAP_W);
  localparam int PHW = $clog2(P);
  localparam int BW  = $clog2(CHAIN_LEN);

  localparam logic [PHW-1:0] PH_LAST   = PHW'(P - 1);
  localparam logic [PHW-1:0] PH_SC0_END = PHW'(PULSE_W);
  localparam logic [PHW-1:0] PH_SC1_BEG = PHW'(PULSE_W + GAP_W);
  localparam logic [PHW-1:0] PH_SC1_END = PHW'(2 * PULSE_W + GAP_W);
  localparam logic [PHW-1:0] PH_SR_LAST = PHW'(PULSE_W - 1);
  localparam logic [BW-1:0]  BIT_LAST   = BW'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CSETUP, S_CAPT, S_SETUP, S_SHIFT, S_HOLD, S_RSTP, S_RESP
  } state_t;

  state_t               state_q, state_d;
  logic [PHW-1:0]       ph_q;
  logic [BW-1:0]        bit_q;
  logic [BW-1:0]        bit_idx;
  logic [CHAIN_LEN-1:0] data_q;
  logic [CHAIN_LEN-1:0] rsp_q;
  logic                 rdy_en_q;
  logic                 accept;
  logic                 sc_phase;

  assign rsp_valid = (state_q == S_RESP);
  assign cmd_ready = rdy_en_q && (state_q == S_IDLE) && !rsp_valid;
  assign busy      = (state_q != S_IDLE);
  assign rsp_data  = rsp_q;
  assign accept    = cmd_valid && cmd_ready;
  assign bit_idx   = BIT_LAST - bit_q;
  assign sc_phase  = (state_q == S_CAPT) || (state_q == S_SHIFT);

  // Next-state and scan control decode
  always_comb begin
    state_d = state_q;
    SE0     = 1'b0;
    SE2     = 1'b0;
    SR      = 1'b0;
    sc_in   = 1'b0;
    SC0     = sc_phase && (ph_q < PH_SC0_END);
    SC1     = sc_phase && (ph_q >= PH_SC1_BEG) && (ph_q < PH_SC1_END);
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            2'b00:   state_d = S_SETUP;
            2'b01:   state_d = S_CSETUP;
            2'b10:   state_d = S_RSTP;
            default: state_d = S_RESP;
          endcase
        end
      end
      S_CSETUP: begin
        SE2     = 1'b1;
        state_d = S_CAPT;
      end
      S_CAPT: begin
        SE2 = 1'b1;
        if (ph_q == PH_LAST) state_d = S_SETUP;
      end
      S_SETUP: begin
        SE0     = 1'b1;
        sc_in   = data_q[CHAIN_LEN-1];
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        SE0   = 1'b1;
        sc_in = data_q[bit_idx];
        if ((ph_q == PH_LAST) && (bit_q == BIT_LAST)) state_d = S_HOLD;
      end
      S_HOLD:  state_d = S_RESP;
      S_RSTP: begin
        SR = 1'b1;
        if (ph_q == PH_SR_LAST) state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, phase/bit counters, command latch and response shift register
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      state_q  <= S_IDLE;
      ph_q     <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      rsp_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      state_q  <= state_d;
      // phase restarts on every state entry and wraps once per bit period
      if ((state_d != state_q) || (ph_q == PH_LAST)) ph_q <= '0;
      else                                           ph_q <= ph_q + PHW'(1);
      if (state_q == S_SETUP)                             bit_q <= '0;
      else if ((state_q == S_SHIFT) && (ph_q == PH_LAST)) bit_q <= bit_q + BW'(1);
      if (accept) begin
        data_q <= cmd_data;
        rsp_q  <= '0;
      end else if ((state_q == S_SHIFT) && (ph_q == '0)) begin
        rsp_q <= {rsp_q[CHAIN_LEN-2:0], sc_out};
      end
    end
  end

`ifdef IO_SCFF_READBACK_CHECK_EN
  logic [CHAIN_LEN-1:0] ref_word_q;
  logic                 ref_vld_q;
  logic                 mism_q;

  // Compare the returned word with the one shifted in by the previous shift
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      ref_word_q <= '0;
      ref_vld_q  <= 1'b0;
      mism_q     <= 1'b0;
    end else begin
      if (accept) begin
        mism_q <= 1'b0;
        if (cmd_op == 2'b10) ref_vld_q <= 1'b0;
      end
      if (state_q == S_HOLD) begin
        mism_q     <= ref_vld_q && (rsp_q != ref_word_q);
        ref_word_q <= data_q;
        ref_vld_q  <= 1'b1;
      end
    end
  end

  assign rsp_mismatch = mism_q && rsp_valid;
`else
  assign rsp_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_io_scff_chain_ctrl.sv
// Testbench for io_scff_chain_ctrl: LSSD chain model on the scan pins,
// scoreboard queue filled by the command driver, checked by a response monitor.
module tb_io_scff_chain_ctrl;
  localparam int N  = 8;
  localparam int PW = 2;
  localparam int GW = 1;
  localparam int P  = 2 * (PW + GW);
  localparam logic [N-1:0] CAP_WORD = 8'h5A;

  logic         prog_clk = 1'b0;
  logic         prog_reset_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b11;
  logic [N-1:0] cmd_data = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [N-1:0] rsp_data;
  logic         rsp_mismatch;
  logic         busy, SE0, SE2, SC0, SC1, SR, sc_in, sc_out;

  io_scff_chain_ctrl #(.CHAIN_LEN(N), .PULSE_W(PW), .GAP_W(GW)) dut (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_mismatch(rsp_mismatch), .busy(busy),
    .SE0(SE0), .SE2(SE2), .SC0(SC0), .SC1(SC1), .SR(SR),
    .sc_in(sc_in), .sc_out(sc_out)
  );

  always #5 prog_clk = ~prog_clk;

  int cyc = 0;
  always @(posedge prog_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Scan chain model: SC0 latches sc_in into the master, SC1 moves it into the
  // chain (or parallel-loads CAP_WORD while SE2 is high); SR clears the chain.
  logic [N-1:0] chain_m = '0;
  logic         master_m = 1'b0;
  logic         sc0_d = 1'b0, sc1_d = 1'b0;
  logic [N-1:0] flip_mask = '0;
  int           flip_cnt = 0;
  int           flip_seen = 0;
  assign sc_out = chain_m[N-1];

  always @(posedge prog_clk) begin
    sc0_d <= SC0;
    sc1_d <= SC1;
    if (SC0 && !sc0_d) master_m <= sc_in;
    if (SR) chain_m <= '0;
    else if (SC1 && !sc1_d) chain_m <= SE2 ? CAP_WORD : {chain_m[N-2:0], master_m};
    else if (flip_cnt != flip_seen) begin
      chain_m   <= chain_m ^ flip_mask;
      flip_seen <= flip_cnt;
    end
  end

  // Response consumer with optional forced backpressure
  logic bp = 1'b0;
  always @(posedge prog_clk) begin
    #1 rsp_ready = bp ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  typedef struct {
    logic [N-1:0] data;
    logic         mism;
    int           lat;
    int           t;
    int           sc;
    int           se0;
    int           se2;
    int           sr;
  } exp_t;

  exp_t q[$];

  // Monitor: invariants every cycle, pulse accounting, response compare
  exp_t cur;
  logic prev_v = 1'b0, prev_taken = 1'b0;
  int   sc0_n = 0, sc1_n = 0, se0_n = 0, se2_n = 0, sr_n = 0;
  int   run0 = 0, run1 = 0, badw = 0;

  always @(negedge prog_clk) begin
    if (!prog_reset_n) begin
      q.delete();
      prev_v = 1'b0; prev_taken = 1'b0;
      sc0_n = 0; sc1_n = 0; se0_n = 0; se2_n = 0; sr_n = 0;
      run0 = 0; run1 = 0; badw = 0;
    end else begin
      chk("invariants", {29'd0, SC0 & SC1, SE0 & SE2, !busy & (SC0 | SC1 | SR)}, 32'd0);
      if (SC0) begin
        if (run0 == 0) sc0_n++;
        run0++;
      end else if (run0 != 0) begin
        if (run0 != PW) badw++;
        run0 = 0;
      end
      if (SC1) begin
        if (run1 == 0) sc1_n++;
        run1++;
      end else if (run1 != 0) begin
        if (run1 != PW) badw++;
        run1 = 0;
      end
      se0_n += int'(SE0);
      se2_n += int'(SE2);
      sr_n  += int'(SR);
      if (prev_v && prev_taken) chk("rsp_valid_drop", rsp_valid, 0);
      if (rsp_valid && !prev_v) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          cur = q.pop_front();
          chk("rsp_data", rsp_data, cur.data);
          chk("rsp_mismatch", rsp_mismatch, cur.mism);
          chk("rsp_latency", cyc - cur.t, cur.lat);
          chk("sc0_pulses", sc0_n, cur.sc);
          chk("sc1_pulses", sc1_n, cur.sc);
          chk("pulse_width", badw, 0);
          chk("se0_cycles", se0_n, cur.se0);
          chk("se2_cycles", se2_n, cur.se2);
          chk("sr_cycles", sr_n, cur.sr);
        end
        sc0_n = 0; sc1_n = 0; se0_n = 0; se2_n = 0; sr_n = 0; badw = 0;
      end else if (rsp_valid) begin
        chk("rsp_data_stable", rsp_data, cur.data);
        chk("rsp_mismatch_stable", rsp_mismatch, cur.mism);
      end
      if (rsp_valid) chk("cmd_ready_in_resp", cmd_ready, 0);
      prev_taken = rsp_valid && rsp_ready;
      prev_v     = rsp_valid;
    end
  end

  // Reference model: the chain simply holds the last word written into it
  logic [N-1:0] chain_word = '0;
  logic [N-1:0] rb_word = '0;
  logic         rb_vld = 1'b0;

  task automatic issue(input logic [1:0] op, input logic [N-1:0] d);
    int   waitc = 0;
    exp_t e;
    @(negedge prog_clk);
    while (!cmd_ready && waitc < 400) begin
      @(negedge prog_clk);
      waitc++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_timeout", 0, 1);
      return;
    end
    e.sc = 0; e.se0 = 0; e.se2 = 0; e.sr = 0; e.mism = 1'b0;
    case (op)
      2'b00: begin
        e.data = chain_word; chain_word = d;
        e.sc = N; e.se0 = 1 + N * P; e.lat = 3 + N * P;
      end
      2'b01: begin
        e.data = CAP_WORD; chain_word = d;
        e.sc = N + 1; e.se0 = 1 + N * P; e.se2 = 1 + P; e.lat = 4 + (N + 1) * P;
      end
      2'b10: begin
        e.data = '0; chain_word = '0;
        e.sr = PW; e.lat = 1 + PW;
      end
      default: begin
        e.data = '0; e.lat = 1;
      end
    endcase
`ifdef IO_SCFF_READBACK_CHECK_EN
    if (op == 2'b00 || op == 2'b01) begin
      e.mism  = rb_vld && (e.data != rb_word);
      rb_word = d;
      rb_vld  = 1'b1;
    end else if (op == 2'b10) begin
      rb_vld = 1'b0;
    end
`endif
    e.t = cyc;
    q.push_back(e);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(posedge prog_clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom_range(0, 3));
    cmd_data  = N'($urandom);
  endtask

  task automatic wait_idle();
    int waitc = 0;
    @(negedge prog_clk);
    while ((q.size() != 0 || !cmd_ready) && waitc < 400) begin
      @(negedge prog_clk);
      waitc++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  task automatic flip(input logic [N-1:0] m);
    wait_idle();
    flip_mask  = m;
    flip_cnt++;
    chain_word = chain_word ^ m;
    @(negedge prog_clk);
    @(negedge prog_clk);
  endtask

  function automatic logic [31:0] all_outs();
    return {14'd0, cmd_ready, rsp_valid, rsp_data, rsp_mismatch, busy,
            SE0, SE2, SC0, SC1, SR, sc_in};
  endfunction

  initial begin
    int waitc;
    logic [1:0] op;

    repeat (3) begin
      @(negedge prog_clk);
      chk("reset_outputs", all_outs(), 0);
    end
    @(posedge prog_clk);
    #1 prog_reset_n = 1'b1;
    @(negedge prog_clk);
    chk("cmd_ready_release_cycle", cmd_ready, 0);
    chk("busy_after_reset", busy, 0);
    @(negedge prog_clk);
    chk("cmd_ready_after_release", cmd_ready, 1);

    flip(N'($urandom));

    issue(2'b00, 8'hA5);
    issue(2'b00, 8'h3C);
    issue(2'b01, 8'h00);
    issue(2'b10, 8'h77);
    issue(2'b00, 8'hFF);
    issue(2'b11, 8'h12);
    issue(2'b00, 8'h81);

    // Backpressure: hold rsp_ready low for 10 response cycles
    wait_idle();
    bp = 1'b1;
    issue(2'b00, N'($urandom));
    waitc = 0;
    while (!rsp_valid && waitc < 100) begin
      @(negedge prog_clk);
      waitc++;
    end
    chk("bp_rsp_valid_seen", rsp_valid, 1);
    repeat (10) begin
      @(negedge prog_clk);
      chk("bp_rsp_valid_held", rsp_valid, 1);
      chk("bp_cmd_ready_low", cmd_ready, 0);
    end
    bp = 1'b0;

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 4) == 0) flip(N'(1) << $urandom_range(0, N - 1));
      op = ($urandom_range(0, 2) != 0) ? 2'b00 : 2'($urandom_range(1, 3));
      issue(op, N'($urandom));
    end

    // Readback: corrupted chain, then clean repeat
    issue(2'b00, 8'hA5);
    flip(8'h08);
    issue(2'b00, 8'h00);
    issue(2'b00, 8'hA5);
    issue(2'b00, 8'h00);
    wait_idle();

    // Reset in the middle of a shift
    issue(2'b00, N'($urandom));
    repeat (20) @(negedge prog_clk);
    chk("midshift_se0", SE0, 1);
    prog_reset_n = 1'b0;
    @(negedge prog_clk);
    chk("midshift_reset_outputs", all_outs(), 0);
    rb_vld = 1'b0;
    @(posedge prog_clk);
    #1 prog_reset_n = 1'b1;
    issue(2'b10, 8'h00);
    issue(2'b00, N'($urandom));
    issue(2'b00, N'($urandom));
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
